usb_endpoint_tx_packer: RTL and testbench
=========================================

Name: usb_endpoint_tx_packer

Overview:
- Synthesizable IN-direction endpoint source for the USB full-speed transactions layer.
- Collects an application byte stream into packets of up to MAX_PKT bytes and offers each packet on the endpoint-transmit handshake.
- Holds each sent packet until the host ACKs it, so an un-ACKed packet is retransmitted unchanged.
- Generates short packets on flush or idle timeout, and zero-length packets (ZLPs) to terminate full-length transfers.

Parameters:
MAX_PKT, 8, maximum packet payload in bytes; power of 2, range 8..64.
IDLE_FLUSH, 1024, cycles of application inactivity with a partial packet before it is auto-flushed; 0 disables.
ZLP_EN, 1, send a ZLP after a flush whose final packet was exactly MAX_PKT bytes.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset; asynchronous, active-low.
i_halt  in  1  endpoint halted (set by control logic).
i_appValid  in  1  application byte valid.
o_appReady  out  1  packer accepts a byte.
i_appData  in  8  application byte.
i_appFlush  in  1  one-cycle pulse: end of transfer; send the partial packet now.
o_etStall  out  1  transactions layer answers IN with STALL.
i_etReady  in  1  transactions layer ready for a packet.
o_etValid  out  1  packet offered.
o_etData  out  8*MAX_PKT  payload; byte 0 in bits [7:0].
o_etData_nBytes  out  $clog2(MAX_PKT)+1  payload length, 0..MAX_PKT.
i_txnType  in  3  one-hot {SETUP, OUT, IN}.
i_etAck  in  1  one-cycle pulse: host ACKed the last sent packet.
i_etTimeout  in  1  one-cycle pulse: no ACK received; retransmit.

Behaviour:
- Reset values (async, i_rst_n low): state FILL; count 0; o_appReady 1; o_etValid 0; o_etData 0; o_etData_nBytes 0; zlpPending 0; flushPending 0; idle counter 0.
- o_etStall = i_halt, combinational.
- o_etValid is forced to 0 while i_halt is high. The packet is retained, not discarded.
- An accept occurs when o_etValid && i_etReady && i_txnType[0].
  - Assert (asrt.vh): at accept, i_txnType is one-hot.
  - Assert: i_etAck and i_etTimeout are never high together.
- State FILL (o_appReady = 1 while count < MAX_PKT):
  - On i_appValid && o_appReady, write the byte at lane `count`, increment count, clear the idle counter.
  - Go to HOLD when any of these holds:
    - count reaches MAX_PKT, in the same cycle the last byte is written;
    - i_appFlush && (count > 0 or the byte written this cycle makes count > 0);
    - i_appFlush && zlpPending, giving a packet with nBytes 0;
    - idle counter == IDLE_FLUSH-1 && count > 0.
  - A flush arriving in the same cycle as the MAX_PKT-th byte sets flushPending, which feeds the ZLP decision below.
  - A flush with count 0 and no zlpPending is ignored.
  - Idle counter increments only while count > 0 and no byte arrives; it saturates.
- State HOLD: o_appReady 0; o_etValid 1 (unless halted); o_etData_nBytes = count. On accept go to WAIT.
- State WAIT: o_etValid 0; o_appReady 0.
  - i_etAck: clear count and payload.
    - If nBytes == MAX_PKT && ZLP_EN && flushPending, set zlpPending and go to HOLD with nBytes 0.
    - Otherwise go to FILL. zlpPending is cleared once the ZLP is ACKed.
  - i_etTimeout: return to HOLD with identical data and length.
- Unused payload lanes are zero.
- A flush received in HOLD or WAIT sets flushPending. It applies to the packet in flight and is cleared on its ACK.
- Data PID toggling is owned by the transactions layer, not this block.
- A reset mid-transfer drops all buffered data with no ACK required.

Decomposition:
- Shared package (usbSpec.vh): txnType bit indices {SETUP=2, OUT=1, IN=0} and state encodings FILL/HOLD/WAIT.
- No sub-module. A free-running idle counter is inline; do not factor it out.

Test Plan:
- Write bytes 0x01..0x08 with MAX_PKT 8, then accept with IN and pulse i_etAck: data=0x0807060504030201, nBytes 8, o_appReady low from the 8th byte until the ACK.
- Write 3 bytes (0xAA, 0xBB, 0xCC), then pulse i_appFlush: HOLD with data 0xCCBBAA, nBytes 3.
- Write 3 bytes with no flush: auto-flush exactly IDLE_FLUSH cycles after the last byte.
- Write 8 bytes with the flush pulsed on the 8th byte; after the ACK, a second packet with nBytes 0 is offered. Repeat with ZLP_EN 0: no ZLP.
- After an accept, pulse i_etTimeout twice, then i_etAck: the same 8-byte packet is offered three times in total, then FILL.
- Raise i_halt in HOLD: o_etStall 1 and o_etValid 0. Drop i_halt: the packet is offered unchanged.
- Assert reset in WAIT: all outputs reach their reset values immediately, asynchronously.

Source files
------------

// File: rtl/usb_endpoint_tx_packer_pkg.sv
// Purpose: shared definitions for the USB IN-endpoint transmit packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: transaction-type bit indices and packer state encoding.
package usb_endpoint_tx_packer_pkg;

  // Bit positions inside the one-hot i_txnType vector.
  localparam int TXN_SETUP = 2;
  localparam int TXN_OUT   = 1;
  localparam int TXN_IN    = 0;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,  // gathering application bytes
    ST_HOLD = 2'd1,  // packet offered to the transactions layer
    ST_WAIT = 2'd2   // packet sent, awaiting ACK or timeout
  } state_e;

endpackage

// File: rtl/usb_endpoint_tx_packer.sv
// Purpose: packs an application byte stream into USB IN packets (max MAX_PKT bytes),
//          holds each until ACKed, and emits short packets / ZLPs on flush or idle.
// Latency: a packet is offered the cycle after its last byte, flush or idle expiry.
// Backpressure: o_appReady drops while a packet is offered or awaiting ACK.
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_halt / o_etStall         endpoint halt; masks o_etValid, answers IN with STALL
//   i_appValid/o_appReady/i_appData/i_appFlush   application byte stream
//   o_etValid/i_etReady/o_etData/o_etData_nBytes packet offer to transactions layer
//   i_txnType, i_etAck, i_etTimeout              transaction type and host outcome
module usb_endpoint_tx_packer
  import usb_endpoint_tx_packer_pkg::*;
#(
  parameter int MAX_PKT    = 8,
  parameter int IDLE_FLUSH = 1024,
  parameter int ZLP_EN     = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_halt,
  input  logic                         i_appValid,
  output logic                         o_appReady,
  input  logic [7:0]                   i_appData,
  input  logic                         i_appFlush,
  output logic                         o_etStall,
  input  logic                         i_etReady,
  output logic                         o_etValid,
  output logic [8*MAX_PKT-1:0]         o_etData,
  output logic [$clog2(MAX_PKT):0]     o_etData_nBytes,
  input  logic [2:0]                   i_txnType,
  input  logic                         i_etAck,
  input  logic                         i_etTimeout
);

  localparam int CW = $clog2(MAX_PKT) + 1;
  // Idle counter only needs to reach IDLE_FLUSH-1.
  localparam int IW = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;
  localparam logic [IW-1:0] IDLE_LAST = (IDLE_FLUSH > 0) ? IW'(IDLE_FLUSH - 1) : '0;
  localparam logic [CW-1:0] FULL = CW'(MAX_PKT);

  state_e               state_q;
  logic [CW-1:0]        count_q, count_d;
  logic [8*MAX_PKT-1:0] data_q, data_d;
  logic [CW-1:0]        nbytes_q;
  logic                 app_ready_q;
  logic                 et_valid_q;
  logic                 zlp_pending_q;
  logic                 flush_pending_q;
  logic [IW-1:0]        idle_q;

  logic wr;
  logic accept;
  logic idle_hit;
  logic fill_done;

  assign wr      = (state_q == ST_FILL) && i_appValid && app_ready_q;
  assign count_d = count_q + CW'(wr);
  assign accept  = o_etValid && i_etReady && i_txnType[TXN_IN];

  // A byte arriving restarts the idle window, so it never coincides with an idle flush.
  assign idle_hit = (IDLE_FLUSH != 0) && !wr && (count_q != '0) && (idle_q == IDLE_LAST);

  assign fill_done = (count_d == FULL)
                   || (i_appFlush && ((count_d != '0) || zlp_pending_q))
                   || idle_hit;

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < MAX_PKT; i++) begin
      if (wr && (count_q == CW'(i))) data_d[i*8 +: 8] = i_appData;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_FILL;
      count_q         <= '0;
      data_q          <= '0;
      nbytes_q        <= '0;
      app_ready_q     <= 1'b1;
      et_valid_q      <= 1'b0;
      zlp_pending_q   <= 1'b0;
      flush_pending_q <= 1'b0;
      idle_q          <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          data_q  <= data_d;
          count_q <= count_d;
          if (wr || (count_q == '0)) idle_q <= '0;
          else if (idle_q != IDLE_LAST) idle_q <= idle_q + 1'b1;
          // Flush landing on the final byte: the full packet ends the transfer.
          if ((count_d == FULL) && i_appFlush) flush_pending_q <= 1'b1;
          if (fill_done) begin
            state_q     <= ST_HOLD;
            app_ready_q <= 1'b0;
            et_valid_q  <= 1'b1;
            nbytes_q    <= count_d;
            idle_q      <= '0;
          end
        end
        ST_HOLD: begin
          if (i_appFlush) flush_pending_q <= 1'b1;
          if (accept) begin
            state_q    <= ST_WAIT;
            et_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_appFlush) flush_pending_q <= 1'b1;
          if (i_etAck) begin
            count_q         <= '0;
            data_q          <= '0;
            nbytes_q        <= '0;
            flush_pending_q <= 1'b0;
            if ((nbytes_q == FULL) && (ZLP_EN != 0) && (flush_pending_q || i_appFlush)) begin
              // Full final packet: terminate the transfer with a zero-length packet.
              zlp_pending_q <= 1'b1;
              state_q       <= ST_HOLD;
              et_valid_q    <= 1'b1;
            end else begin
              zlp_pending_q <= 1'b0;
              state_q       <= ST_FILL;
              app_ready_q   <= 1'b1;
            end
          end else if (i_etTimeout) begin
            state_q    <= ST_HOLD;
            et_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign o_appReady      = app_ready_q;
  assign o_etStall       = i_halt;
  // Halt only masks the offer; the held packet is kept for later.
  assign o_etValid       = et_valid_q && !i_halt;
  assign o_etData        = data_q;
  assign o_etData_nBytes = nbytes_q;

  a_txn_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    accept |-> $onehot(i_txnType));
  a_ack_timeout_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_etAck && i_etTimeout));

endmodule

// File: tb/tb_usb_endpoint_tx_packer.sv
module tb_usb_endpoint_tx_packer;

  localparam int IDLE = 20;

  logic        clk = 1'b0;
  logic        rst_n, halt, app_valid, app_flush, et_ready, et_ack, et_timeout;
  logic [7:0]  app_data;
  logic [2:0]  txn;

  logic        app_ready, et_stall, et_valid;
  logic [63:0] et_data;
  logic [3:0]  et_n;
  logic        z_ready, z_stall, z_valid;
  logic [63:0] z_data;
  logic [3:0]  z_n;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  n;
  } pkt_t;
  pkt_t exp_q[$];

  always #5 clk = ~clk;

  usb_endpoint_tx_packer #(.MAX_PKT(8), .IDLE_FLUSH(IDLE), .ZLP_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt),
    .i_appValid(app_valid), .o_appReady(app_ready), .i_appData(app_data), .i_appFlush(app_flush),
    .o_etStall(et_stall), .i_etReady(et_ready), .o_etValid(et_valid),
    .o_etData(et_data), .o_etData_nBytes(et_n),
    .i_txnType(txn), .i_etAck(et_ack), .i_etTimeout(et_timeout));

  usb_endpoint_tx_packer #(.MAX_PKT(8), .IDLE_FLUSH(IDLE), .ZLP_EN(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt),
    .i_appValid(app_valid), .o_appReady(z_ready), .i_appData(app_data), .i_appFlush(app_flush),
    .o_etStall(z_stall), .i_etReady(et_ready), .o_etValid(z_valid),
    .o_etData(z_data), .o_etData_nBytes(z_n),
    .i_txnType(txn), .i_etAck(et_ack), .i_etTimeout(et_timeout));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted packet must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && et_valid && et_ready && txn[0]) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got packet n=%0d data=%h want none", et_n, et_data);
      end else begin
        check("sb_data", et_data, exp_q[0].d);
        check("sb_nbytes", 64'(et_n), 64'(exp_q[0].n));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [63:0] d, input logic [3:0] n);
    pkt_t p;
    p.d = d;
    p.n = n;
    exp_q.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    app_valid = 1'b1;
    app_data  = b;
    app_flush = fl;
    tick();
    app_valid = 1'b0;
    app_flush = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!et_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, 64'(et_valid), 64'd1);
  endtask

  task automatic accept();
    et_ready = 1'b1;
    tick();
    et_ready = 1'b0;
  endtask

  task automatic ack();
    et_ack = 1'b1;
    tick();
    et_ack = 1'b0;
  endtask

  task automatic timeout();
    et_timeout = 1'b1;
    tick();
    et_timeout = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; halt = 1'b0; app_valid = 1'b0; app_flush = 1'b0;
    et_ready = 1'b0; et_ack = 1'b0; et_timeout = 1'b0; app_data = 8'h00; txn = 3'b001;

    // Reset state
    #12;
    check("rst_ready", 64'(app_ready), 64'd1);
    check("rst_valid", 64'(et_valid), 64'd0);
    check("rst_data", et_data, 64'd0);
    check("rst_nbytes", 64'(et_n), 64'd0);
    check("rst_stall", 64'(et_stall), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Full packet 0x01..0x08
    push(64'h0807060504030201, 4'd8);
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
    check("full_rdy_before", 64'(app_ready), 64'd1);
    send(8'h08, 1'b0);
    check("full_rdy_low", 64'(app_ready), 64'd0);
    wait_valid("full_valid");
    accept();
    check("full_rdy_wait", 64'(app_ready), 64'd0);
    check("full_valid_wait", 64'(et_valid), 64'd0);
    ack();
    check("full_rdy_after_ack", 64'(app_ready), 64'd1);
    check("full_valid_after_ack", 64'(et_valid), 64'd0);

    // Short packet by flush
    push(64'h0000000000CCBBAA, 4'd3);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
    app_flush = 1'b1; tick(); app_flush = 1'b0;
    check("flush_valid", 64'(et_valid), 64'd1);
    check("flush_nbytes", 64'(et_n), 64'd3);
    check("flush_data", et_data, 64'h0000000000CCBBAA);
    accept();
    ack();

    // Idle auto-flush exactly IDLE cycles after the last byte
    push(64'h0000000000332211, 4'd3);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    k = 0;
    while (!et_valid && k < 2 * IDLE) begin
      tick();
      k++;
    end
    check("idle_cycles", 64'(k), 64'(IDLE));
    accept();
    ack();

    // Flush on the 8th byte: ZLP follows when enabled, not when disabled
    push(64'h1716151413121110, 4'd8);
    push(64'd0, 4'd0);
    for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1'b0);
    send(8'h17, 1'b1);
    wait_valid("zlp_first_valid");
    accept();
    ack();
    check("zlp_valid", 64'(et_valid), 64'd1);
    check("zlp_nbytes", 64'(et_n), 64'd0);
    check("zlp_data", et_data, 64'd0);
    check("nozlp_valid", 64'(z_valid), 64'd0);
    check("nozlp_ready", 64'(z_ready), 64'd1);
    accept();
    ack();
    check("zlp_done_ready", 64'(app_ready), 64'd1);
    check("zlp_done_valid", 64'(et_valid), 64'd0);

    // Two timeouts then ACK: same packet accepted three times
    for (int r = 0; r < 3; r++) push(64'hA7A6A5A4A3A2A1A0, 4'd8);
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b0);
    wait_valid("to_valid1");
    accept();
    timeout();
    wait_valid("to_valid2");
    accept();
    timeout();
    wait_valid("to_valid3");
    accept();
    ack();
    check("to_ready_after", 64'(app_ready), 64'd1);
    check("to_valid_after", 64'(et_valid), 64'd0);

    // Halt in HOLD: stall, no offer, packet kept
    push(64'h000000000000A55A, 4'd2);
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b1);
    halt = 1'b1;
    #1;
    check("halt_stall", 64'(et_stall), 64'd1);
    check("halt_valid", 64'(et_valid), 64'd0);
    et_ready = 1'b1;
    tick(); tick();
    et_ready = 1'b0;
    check("halt_valid_hold", 64'(et_valid), 64'd0);
    halt = 1'b0;
    #1;
    check("unhalt_stall", 64'(et_stall), 64'd0);
    check("unhalt_valid", 64'(et_valid), 64'd1);
    check("unhalt_nbytes", 64'(et_n), 64'd2);
    check("unhalt_data", et_data, 64'h000000000000A55A);
    accept();
    ack();

    // Asynchronous reset in WAIT
    push(64'hC7C6C5C4C3C2C1C0, 4'd8);
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b0);
    wait_valid("arst_valid_pre");
    accept();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(app_ready), 64'd1);
    check("arst_valid", 64'(et_valid), 64'd0);
    check("arst_data", et_data, 64'd0);
    check("arst_nbytes", 64'(et_n), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    push(64'h0000000000000077, 4'd1);
    send(8'h77, 1'b1);
    wait_valid("post_rst_valid");
    check("post_rst_nbytes", 64'(et_n), 64'd1);
    accept();
    ack();

    tick();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
